vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz `vga_clk`. It drives `hsync`/`vsync`/`de` to the DAC and requests pixels from the downstream renderer (`vga_display`) through `pixel_xpos`/`pixel_ypos`. It accepts the renderer's registered `pixel_data` one clock later and gates it onto `vga_rgb`. The request window leads the active window by one clock, which absorbs the renderer's 1-cycle output register.

---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: sync/enable decode plus a pixel request
// window that leads active video by one clock to cover the renderer's output register.
module vga_timing_gen #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned V_TOTAL = 525
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [11:0] pixel_data,
    output logic [9:0]  pixel_xpos,
    output logic [9:0]  pixel_ypos,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [11:0] vga_rgb,
    output logic        frame_start,
    output logic        line_start
);

    localparam int unsigned HA = H_SYNC + H_BACK;
    localparam int unsigned VA = V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(HA);
    localparam logic [9:0] H_ACT_END   = 10'(HA + H_DISP);
    localparam logic [9:0] V_ACT_START = 10'(VA);
    localparam logic [9:0] V_ACT_END   = 10'(VA + V_DISP);
    localparam logic [9:0] H_REQ_START = 10'(HA - 1);
    localparam logic [9:0] H_REQ_END   = 10'(HA + H_DISP - 1);

    // Catch inconsistent timing sets at elaboration rather than in the lab.
    if (H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) begin : g_h_total_check
        $error("vga_timing_gen: horizontal timing parameters do not sum to H_TOTAL");
    end
    if (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL) begin : g_v_total_check
        $error("vga_timing_gen: vertical timing parameters do not sum to V_TOTAL");
    end

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    logic h_act;
    logic v_act;
    logic h_req;
    logic req;

    assign h_act = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    assign v_act = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    assign h_req = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END);
    assign req   = h_req && v_act;

    // Reset overrides the decode so the DAC sees blanking with sync deasserted.
    always_comb begin
        vga_hs      = 1'b1;
        vga_vs      = 1'b1;
        vga_de      = 1'b0;
        vga_rgb     = 12'h000;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        if (!rst) begin
            vga_hs      = !(h_cnt < H_SYNC_END);
            vga_vs      = !(v_cnt < V_SYNC_END);
            vga_de      = h_act && v_act;
            vga_rgb     = (h_act && v_act) ? pixel_data : 12'h000;
            line_start  = (h_cnt == '0);
            frame_start = (h_cnt == '0) && (v_cnt == '0);
            if (req) begin
                pixel_xpos = h_cnt - H_REQ_START;
                pixel_ypos = v_cnt - V_ACT_START;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; vertical timing shrunk to 11 lines per frame
// (sync 2, back 3, active 4, front 2) so whole frames fit a short run.
module tb_vga_timing_gen;

    localparam int HT    = 800;
    localparam int VT    = 11;
    localparam int FRAME = HT * VT;

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_data = 12'h000;
    logic [9:0]  pixel_xpos;
    logic [9:0]  pixel_ypos;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [11:0] vga_rgb;
    logic        frame_start;
    logic        line_start;

    int checks = 0;
    int failures = 0;
    int hc = 0;
    int vc = 0;

    localparam logic [36:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 12'h000, 10'd0, 10'd0, 1'b0, 1'b0};

    vga_timing_gen #(
        .V_SYNC (2),
        .V_BACK (3),
        .V_DISP (4),
        .V_FRONT(2),
        .V_TOTAL(11)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .pixel_data (pixel_data),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_de     (vga_de),
        .vga_rgb    (vga_rgb),
        .frame_start(frame_start),
        .line_start (line_start)
    );

    always #5 vga_clk = ~vga_clk;

    // Renderer stand-in: registers the requested column as the pixel value.
    always @(posedge vga_clk) pixel_data <= {2'b00, pixel_xpos};

    function automatic logic [36:0] outs();
        return {vga_hs, vga_vs, vga_de, vga_rgb, pixel_xpos, pixel_ypos, frame_start, line_start};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
        if (!rst) begin
            if (hc == HT - 1) begin
                hc = 0;
                vc = (vc == VT - 1) ? 0 : vc + 1;
            end else begin
                hc++;
            end
        end
    endtask

    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        while (!(hc == h && vc == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
    endtask

    task automatic release_rst();
        @(negedge vga_clk);
        #4;
        rst = 1'b0;
        hc = 0;
        vc = 0;
    endtask

    initial begin
        int n;
        int hs_low, vs_low, de_n, de_first, ls_n, fs_n, rgb_bad;

        // Power-on reset
        repeat (3) tick();
        chk("reset_outputs_poweron", outs(), RESET_VEC);

        release_rst();
        n = 0;
        do begin
            tick();
            n++;
        end while (!line_start && n < 2000);
        chk("first_line_start_delay", n, 800);
        chk("no_frame_start_on_line1", frame_start, 0);
        chk("hs_low_at_wrap", vga_hs, 0);
        while (!frame_start && n < 3 * FRAME) begin
            tick();
            n++;
        end
        chk("first_frame_start_delay", n, FRAME);
        chk("line_start_with_frame_start", line_start, 1);

        // One full frame, line by line
        for (int l = 0; l < VT; l++) begin
            hs_low = 0; vs_low = 0; de_n = 0; de_first = -1; ls_n = 0; fs_n = 0; rgb_bad = 0;
            for (int h = 0; h < HT; h++) begin
                if (!vga_hs) hs_low++;
                if (!vga_vs) vs_low++;
                if (line_start) ls_n++;
                if (frame_start) fs_n++;
                if (vga_de) begin
                    de_n++;
                    if (de_first < 0) de_first = h;
                    if (vga_rgb !== 12'(h - 144)) rgb_bad++;
                end else if (vga_rgb !== 12'h000) begin
                    rgb_bad++;
                end
                tick();
            end
            chk($sformatf("hs_low_line%0d", l), hs_low, 96);
            chk($sformatf("vs_low_line%0d", l), vs_low, (l < 2) ? 800 : 0);
            chk($sformatf("line_start_count_line%0d", l), ls_n, 1);
            chk($sformatf("frame_start_count_line%0d", l), fs_n, (l == 0) ? 1 : 0);
            chk($sformatf("de_count_line%0d", l), de_n, (l >= 5 && l < 9) ? 640 : 0);
            if (l >= 5 && l < 9) chk($sformatf("de_first_line%0d", l), de_first, 144);
            chk($sformatf("rgb_bad_line%0d", l), rgb_bad, 0);
        end
        chk("frame_start_period", frame_start, 1);

        // Request/data alignment on the first active line
        goto(142, 5);
        chk("x_before_req", pixel_xpos, 0);
        goto(143, 5);
        chk("x_req_open", pixel_xpos, 0);
        chk("de_at_143", vga_de, 0);
        goto(144, 5);
        chk("de_at_144", vga_de, 1);
        chk("rgb_at_144", vga_rgb, 0);
        chk("x_at_144", pixel_xpos, 1);
        goto(300, 5);
        chk("x_at_300", pixel_xpos, 157);
        chk("y_first_row", pixel_ypos, 0);
        goto(782, 5);
        chk("x_last_req", pixel_xpos, 639);
        goto(783, 5);
        chk("rgb_at_783", vga_rgb, 639);
        chk("de_at_783", vga_de, 1);
        chk("x_at_783", pixel_xpos, 0);
        chk("y_at_783", pixel_ypos, 0);
        goto(784, 5);
        chk("de_at_784", vga_de, 0);
        chk("rgb_at_784", vga_rgb, 0);

        // Row mapping at the last active line and the first front-porch line
        goto(300, 8);
        chk("y_last_row", pixel_ypos, 3);
        goto(300, 9);
        chk("x_front_porch", pixel_xpos, 0);
        chk("y_front_porch", pixel_ypos, 0);
        chk("de_front_porch", vga_de, 0);
        goto(50, 0);
        chk("hs_vs_low_frame_top", {vga_hs, vga_vs}, 2'b00);

        // Mid-frame reset
        goto(400, 7);
        chk("de_before_midreset", vga_de, 1);
        chk("rgb_before_midreset", vga_rgb, 256);
        rst = 1'b1;
        #1;
        chk("midreset_immediate", outs(), RESET_VEC);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("midreset_hold%0d", i), outs(), RESET_VEC);
        end
        release_rst();
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 3 * FRAME);
        chk("frame_start_after_midreset", n, FRAME);
        chk("line_start_after_midreset", line_start, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
